// File: rtl/pc_unit_if.sv
// pc_unit_if: groups the control inputs and status outputs of pc_unit.
// Optional build macro: PC_ALIGN_CHECK_EN adds the misalign status signal.
//
// Handshake: there is no valid/ready pair. pcWEN is a level-sensitive update
// enable sampled on every rising edge. 1 = advance (PC and RAS may change),
// 0 = stall (everything holds). halt is sampled only when pcWEN=1.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             pcWEN;
  logic             halt;
  logic [1:0]       pc_sel;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] jr_target;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;
  logic             halted;
`ifdef PC_ALIGN_CHECK_EN
  logic             misalign;
`endif

  // Control side: drives requests, observes PC and status.
  modport master (
    output pcWEN, halt, pc_sel, branch_target, jump_target, jr_target,
           ras_push, ras_pop,
    input  pc_out, pc_plus_inc, ras_empty, ras_full, ras_overflow,
           ras_underflow, halted
`ifdef PC_ALIGN_CHECK_EN
    , input misalign
`endif
  );

  // PC unit side.
  modport slave (
    input  pcWEN, halt, pc_sel, branch_target, jump_target, jr_target,
           ras_push, ras_pop,
    output pc_out, pc_plus_inc, ras_empty, ras_full, ras_overflow,
           ras_underflow, halted
`ifdef PC_ALIGN_CHECK_EN
    , output misalign
`endif
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: architectural program counter with next-PC selection
// (sequential / branch / jump / jump-register), stall, sticky halt and a
// circular return-address stack (RAS) for call/return prediction.
// Optional build macro: PC_ALIGN_CHECK_EN -- rejects next-PC values that are
// not a multiple of INC, raising a sticky misalign flag and halting.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic       CLK,
  input logic       RST,
  pc_unit_if.slave  bus
);

  localparam int               PW      = $clog2(RAS_DEPTH);
  localparam int               CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

  // Architectural state
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_halted;

  // Decoded control
  logic             w_act;
  logic             w_commit;
  logic             w_pop_req;
  logic             w_pop_ok;
  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_link;
  logic [WIDTH-1:0] w_next_pc;
  logic [PW-1:0]    w_top_inc;
  logic [PW-1:0]    w_top_dec;

  assign w_act     = bus.pcWEN & ~r_halted;
  assign w_link    = r_pc + INC_W;          // wraps modulo 2^WIDTH
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  // A pop only means something together with the jr/return source.
  assign w_pop_req = bus.ras_pop & (bus.pc_sel == 2'b11);
  assign w_pop_ok  = w_pop_req & ~w_empty;
  // RAS_DEPTH is a power of two, so the pointer wraps naturally.
  assign w_top_inc = r_top + PW'(1);
  assign w_top_dec = r_top - PW'(1);

  // Next-PC source selection; an empty-stack return falls back to jr_target.
  always_comb begin
    w_next_pc = w_link;
    case (bus.pc_sel)
      2'b00:   w_next_pc = w_link;
      2'b01:   w_next_pc = bus.branch_target;
      2'b10:   w_next_pc = bus.jump_target;
      default: w_next_pc = w_pop_ok ? r_ras[r_top] : bus.jr_target;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_misalign;

  // A misaligned target blocks the whole update: neither PC nor RAS change.
  assign w_misaligned = ((w_next_pc % INC_W) != '0);
  assign w_commit     = w_act & ~w_misaligned;
  assign bus.misalign = r_misalign;

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                       r_misalign <= 1'b0;
    else if (w_act & w_misaligned) r_misalign <= 1'b1;
  end
`else
  assign w_commit = w_act;
`endif

  // Program counter register: loads the selected source on a committed edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_pc <= RESET_PC;
    else if (w_commit) r_pc <= w_next_pc;
  end

  // Sticky halt: the edge that sees halt still updates the PC, then it freezes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_halted <= 1'b0;
    end else begin
      if (w_act & bus.halt) r_halted <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      if (w_act & w_misaligned) r_halted <= 1'b1;
`endif
    end
  end

  // Return-address stack: circular buffer, top points at the newest entry.
  // When full, top+1 is the oldest entry, so a push simply overwrites it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_commit) begin
      if (bus.ras_push && w_pop_ok) begin
        // Call and return together: target was the old top, link replaces it.
        r_ras[r_top] <= w_link;
      end else if (bus.ras_push) begin
        r_ras[w_top_inc] <= w_link;
        r_top            <= w_top_inc;
        if (!w_full) r_count <= r_count + CW'(1);
        else         r_ovf   <= 1'b1;
      end else if (w_pop_ok) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CW'(1);
      end
      if (w_pop_req && w_empty) r_unf <= 1'b1;
    end
  end

  assign bus.pc_out        = r_pc;
  assign bus.pc_plus_inc   = w_link;
  assign bus.ras_empty     = w_empty;
  assign bus.ras_full      = w_full;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
  assign bus.halted        = r_halted;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven bench for pc_unit (WIDTH=32, RESET_PC=0x100,
// INC=4, RAS_DEPTH=4) with an expected-value queue and hand-written
// sequences for asynchronous reset and, when PC_ALIGN_CHECK_EN is defined,
// the alignment check.
module tb_pc_unit;

  localparam int EW = 37; // {pc[31:0], empty, full, ovf, unf, halted}

  typedef struct {
    logic        wen;
    logic        halt;
    logic [1:0]  sel;
    logic [31:0] br;
    logic [31:0] jt;
    logic [31:0] jr;
    logic        push;
    logic        pop;
    logic [31:0] e_pc;
    logic        e_empty;
    logic        e_full;
    logic        e_ovf;
    logic        e_unf;
    logic        e_halted;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h100),
    .INC      (4),
    .RAS_DEPTH(4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expected record and compare all visible outputs.
  task automatic check_outputs(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected queue empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".pc_out"},        bus.pc_out,               e[36:5]);
    check({tag, ".pc_plus_inc"},   bus.pc_plus_inc,          e[36:5] + 32'h4);
    check({tag, ".ras_empty"},     32'(bus.ras_empty),       32'(e[4]));
    check({tag, ".ras_full"},      32'(bus.ras_full),        32'(e[3]));
    check({tag, ".ras_overflow"},  32'(bus.ras_overflow),    32'(e[2]));
    check({tag, ".ras_underflow"}, 32'(bus.ras_underflow),   32'(e[1]));
    check({tag, ".halted"},        32'(bus.halted),          32'(e[0]));
  endtask

  task automatic add_vec(input logic wen, input logic halt, input logic [1:0] sel,
                         input logic [31:0] br, input logic [31:0] jt, input logic [31:0] jr,
                         input logic push, input logic pop, input logic [31:0] e_pc,
                         input logic e_empty, input logic e_full, input logic e_ovf,
                         input logic e_unf, input logic e_halted);
    vec_t v;
    v.wen = wen; v.halt = halt; v.sel = sel; v.br = br; v.jt = jt; v.jr = jr;
    v.push = push; v.pop = pop; v.e_pc = e_pc; v.e_empty = e_empty;
    v.e_full = e_full; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_halted = e_halted;
    vecs.push_back(v);
  endtask

  // Driver: apply one vector, queue its expectation, clock, then compare.
  task automatic apply(input vec_t v, input string tag);
    bus.pcWEN         = v.wen;
    bus.halt          = v.halt;
    bus.pc_sel        = v.sel;
    bus.branch_target = v.br;
    bus.jump_target   = v.jt;
    bus.jr_target     = v.jr;
    bus.ras_push      = v.push;
    bus.ras_pop       = v.pop;
    exp_q.push_back({v.e_pc, v.e_empty, v.e_full, v.e_ovf, v.e_unf, v.e_halted});
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.pcWEN = 1'b0; bus.halt = 1'b0; bus.pc_sel = 2'b00;
    bus.branch_target = '0; bus.jump_target = '0; bus.jr_target = '0;
    bus.ras_push = 1'b0; bus.ras_pop = 1'b0;

    //      wen halt sel br        jt        jr        psh pop e_pc      emp ful ovf unf hlt
    // sequential
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     0, 0, 32'h104,   1, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     0, 0, 32'h108,   1, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     0, 0, 32'h10C,   1, 0, 0, 0, 0);
    // stall then jump
    add_vec(0, 0, 2'b10, 32'h0,   32'h400, 32'h0,     0, 0, 32'h10C,   1, 0, 0, 0, 0);
    add_vec(0, 0, 2'b10, 32'h0,   32'h400, 32'h0,     0, 0, 32'h10C,   1, 0, 0, 0, 0);
    add_vec(1, 0, 2'b10, 32'h0,   32'h400, 32'h0,     0, 0, 32'h400,   1, 0, 0, 0, 0);
    // call / return
    add_vec(1, 0, 2'b10, 32'h0,   32'h200, 32'h0,     0, 0, 32'h200,   1, 0, 0, 0, 0);
    add_vec(1, 0, 2'b10, 32'h0,   32'h800, 32'h0,     1, 0, 32'h800,   0, 0, 0, 0, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'h204,   1, 0, 0, 0, 0);
    // fill past depth from pc 0
    add_vec(1, 0, 2'b10, 32'h0,   32'h0,   32'h0,     0, 0, 32'h0,     1, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'h4,     0, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'h8,     0, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'hC,     0, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'h10,    0, 1, 0, 0, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'h14,    0, 1, 1, 0, 0);
    // pop with a non-return source is ignored
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'h18,    0, 1, 1, 0, 0);
    // four returns, then underflow
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'h14,    0, 0, 1, 0, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'h10,    0, 0, 1, 0, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'hC,     0, 0, 1, 0, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'h8,     1, 0, 1, 0, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'hDEAD0, 0, 1, 32'hDEAD0, 1, 0, 1, 1, 0);
    // push+pop in one cycle, non-empty then empty
    add_vec(1, 0, 2'b10, 32'h0,   32'h500, 32'h0,     0, 0, 32'h500,   1, 0, 1, 1, 0);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'h504,   0, 0, 1, 1, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'h999,   1, 1, 32'h504,   0, 0, 1, 1, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'h999,   0, 1, 32'h508,   1, 0, 1, 1, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'h600,   1, 1, 32'h600,   0, 0, 1, 1, 0);
    add_vec(1, 0, 2'b11, 32'h0,   32'h0,   32'h0,     0, 1, 32'h50C,   1, 0, 1, 1, 0);
    // halt: ignored while stalled, then taken with a branch, then frozen
    add_vec(0, 1, 2'b00, 32'h0,   32'h0,   32'h0,     0, 0, 32'h50C,   1, 0, 1, 1, 0);
    add_vec(1, 1, 2'b01, 32'h300, 32'h0,   32'h0,     0, 0, 32'h300,   1, 0, 1, 1, 1);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     0, 0, 32'h300,   1, 0, 1, 1, 1);
    add_vec(1, 0, 2'b00, 32'h0,   32'h0,   32'h0,     1, 0, 32'h300,   1, 0, 1, 1, 1);
    add_vec(1, 0, 2'b10, 32'h0,   32'h700, 32'h0,     0, 0, 32'h300,   1, 0, 1, 1, 1);

    // Reset state
    #12;
    rst = 1'b0;
    #1;
    exp_q.push_back({32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check_outputs("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges while halted
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back({32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check_outputs("async_rst");
    #1;
    rst = 1'b0;

    // Sequential step after reset, randomised unused targets
    v.wen = 1; v.halt = 0; v.sel = 2'b00; v.push = 0; v.pop = 0;
    v.br = $urandom_range(0, 32'hFFFF) << 2;
    v.jt = $urandom_range(0, 32'hFFFF) << 2;
    v.jr = $urandom_range(0, 32'hFFFF) << 2;
    v.e_pc = 32'h104; v.e_empty = 1; v.e_full = 0; v.e_ovf = 0; v.e_unf = 0; v.e_halted = 0;
    apply(v, "post_rst_seq");

`ifdef PC_ALIGN_CHECK_EN
    check("misalign_pre", 32'(bus.misalign), 32'h0);
    v.sel = 2'b01; v.br = 32'h302; v.push = 1;
    v.e_pc = 32'h104; v.e_empty = 1; v.e_halted = 1;
    apply(v, "misalign");
    check("misalign_flag", 32'(bus.misalign), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
